oled_cmd_seq: RTL

OLED_CMD_SEQ -- requirements
Module: oled_cmd_seq

---
 rtl/oled_cmd_seq.sv | 297 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/oled_cmd_seq.sv
// oled_cmd_seq -- OLED power-up / command sequencer.
//
// Holds the panel in hard reset, lets it settle, then walks a command ROM.
// Each 10-bit entry is {type[1:0], byte[7:0]}:
//   00 command byte (DC=0), 01 display-data byte (DC=1),
//   10 delay of byte*DELAY_UNIT cycles, 11 end of table.
// Every byte goes out through a WRITE_START / WRITE_DONE handshake with an
// external SPI engine. The table stops at DEPTH-1 even without an end marker.
//
// Optional feature: define OLED_CMD_SEQ_TIMEOUT_EN to enable a WRITE_DONE
// watchdog. When it fires, the sequencer enters ERR, raises the sticky ERROR
// flag and returns to IDLE without pulsing DONE. Without the macro, WRITE
// waits indefinitely and ERROR stays 0.

module oled_cmd_seq #(
  parameter int AW           = 5,
  parameter int DEPTH        = 32,
  parameter int RST_LOW_CYC  = 100000,
  parameter int RST_WAIT_CYC = 1000,
  parameter int DELAY_UNIT   = 1000,
  parameter int TIMEOUT_CYC  = 4096
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  output logic          DONE,
  output logic          BUSY,
  output logic          ERROR,
  output logic          WRITE_START,
  input  logic          WRITE_DONE,
  output logic [7:0]    DATA,
  output logic          DC,
  output logic          RST_OLED,
  output logic [AW-1:0] ROM_ADDR,
  input  logic [9:0]    ROM_DATA
);

  // One shared counter covers the reset timers, the delay timer and the
  // watchdog. It is sized for the largest of them so it never wraps.
  localparam int DLY_MAX = 255 * DELAY_UNIT;
  localparam int MAX_A   = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
  localparam int MAX_B   = (DLY_MAX > TIMEOUT_CYC) ? DLY_MAX : TIMEOUT_CYC;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LOW_LAST  = CW'(RST_LOW_CYC - 1);
  localparam logic [CW-1:0] RST_WAIT_LAST = CW'(RST_WAIT_CYC - 1);
`ifdef OLED_CMD_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LAST      = CW'(TIMEOUT_CYC - 1);
`endif
  localparam logic [AW-1:0] ADDR_LAST     = AW'(DEPTH - 1);

  // State encoding
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_RST_LOW  = 4'd1;
  localparam logic [3:0] ST_RST_WAIT = 4'd2;
  localparam logic [3:0] ST_FETCH    = 4'd3;
  localparam logic [3:0] ST_DECODE   = 4'd4;
  localparam logic [3:0] ST_WRITE    = 4'd5;
  localparam logic [3:0] ST_DELAY    = 4'd6;
  localparam logic [3:0] ST_FINISH   = 4'd7;
  localparam logic [3:0] ST_ERR      = 4'd8;

  // ROM entry types
  localparam logic [1:0] TY_CMD   = 2'b00;
  localparam logic [1:0] TY_DATA  = 2'b01;
  localparam logic [1:0] TY_DELAY = 2'b10;
  localparam logic [1:0] TY_END   = 2'b11;

  // Registers
  logic [3:0]    state_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] delay_len_r;
  logic [AW-1:0] rom_addr_r;
  logic [7:0]    data_r;
  logic          dc_r;
  logic          write_start_r;
  logic          rst_oled_r;
  logic          done_r;
  logic          busy_r;
  logic          error_r;
  logic          start_d_r;

  // Next-state values
  logic [3:0]    state_s;
  logic [CW-1:0] cnt_s;
  logic [CW-1:0] delay_len_s;
  logic [AW-1:0] rom_addr_s;
  logic [7:0]    data_s;
  logic          dc_s;
  logic          write_start_s;
  logic          rst_oled_s;
  logic          done_s;
  logic          busy_s;
  logic          error_s;

  // Helpers
  logic          start_rise_s;
  logic [1:0]    rom_type_s;
  logic [7:0]    rom_byte_s;
  logic [3:0]    adv_state_s;
  logic [AW-1:0] adv_addr_s;

  assign start_rise_s = START & ~start_d_r;
  assign rom_type_s   = ROM_DATA[9:8];
  assign rom_byte_s   = ROM_DATA[7:0];

  // Where to go after an entry completes: the last entry ends the run,
  // otherwise fetch the next address.
  always_comb begin
    if (rom_addr_r == ADDR_LAST) begin
      adv_state_s = ST_FINISH;
      adv_addr_s  = rom_addr_r;
    end else begin
      adv_state_s = ST_FETCH;
      adv_addr_s  = rom_addr_r + AW'(1);
    end
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    delay_len_s   = delay_len_r;
    rom_addr_s    = rom_addr_r;
    data_s        = data_r;
    dc_s          = dc_r;
    write_start_s = write_start_r;
    rst_oled_s    = rst_oled_r;
    error_s       = error_r;

    case (state_r)
      ST_IDLE: begin
        if (start_rise_s) begin
          state_s    = ST_RST_LOW;
          rom_addr_s = {AW{1'b0}};
          error_s    = 1'b0;
          rst_oled_s = 1'b0;
          cnt_s      = {CW{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_RST_LOW: begin
        if (cnt_r == RST_LOW_LAST) begin
          state_s    = ST_RST_WAIT;
          rst_oled_s = 1'b1;
          cnt_s      = {CW{1'b0}};
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end

      ST_RST_WAIT: begin
        if (cnt_r == RST_WAIT_LAST) begin
          state_s = ST_FETCH;
          cnt_s   = {CW{1'b0}};
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end

      // ROM_ADDR is stable here, so ROM_DATA is valid in DECODE.
      ST_FETCH: begin
        state_s = ST_DECODE;
      end

      ST_DECODE: begin
        cnt_s = {CW{1'b0}};
        case (rom_type_s)
          TY_CMD: begin
            data_s        = rom_byte_s;
            dc_s          = 1'b0;
            write_start_s = 1'b1;
            state_s       = ST_WRITE;
          end
          TY_DATA: begin
            data_s        = rom_byte_s;
            dc_s          = 1'b1;
            write_start_s = 1'b1;
            state_s       = ST_WRITE;
          end
          TY_DELAY: begin
            if (rom_byte_s == 8'd0) begin
              state_s    = adv_state_s;
              rom_addr_s = adv_addr_s;
            end else begin
              delay_len_s = CW'(rom_byte_s) * CW'(DELAY_UNIT);
              state_s     = ST_DELAY;
            end
          end
          TY_END: begin
            state_s = ST_FINISH;
          end
          default: begin
            state_s = ST_FINISH;
          end
        endcase
      end

      // WRITE_DONE only counts once WRITE_START has been presented.
      ST_WRITE: begin
        if (write_start_r && WRITE_DONE) begin
          write_start_s = 1'b0;
          state_s       = adv_state_s;
          rom_addr_s    = adv_addr_s;
          cnt_s         = {CW{1'b0}};
        end
`ifdef OLED_CMD_SEQ_TIMEOUT_EN
        else if (cnt_r == TMO_LAST) begin
          write_start_s = 1'b0;
          error_s       = 1'b1;
          state_s       = ST_ERR;
          cnt_s         = {CW{1'b0}};
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
`else
        else begin
          cnt_s = cnt_r;
        end
`endif
      end

      ST_DELAY: begin
        if (cnt_r == (delay_len_r - CW'(1))) begin
          state_s    = adv_state_s;
          rom_addr_s = adv_addr_s;
          cnt_s      = {CW{1'b0}};
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end

      ST_FINISH: begin
        state_s = ST_IDLE;
      end

      // ERROR stays set until the next accepted START.
      ST_ERR: begin
        write_start_s = 1'b0;
        state_s       = ST_IDLE;
      end

      default: begin
        write_start_s = 1'b0;
        cnt_s         = {CW{1'b0}};
        state_s       = ST_IDLE;
      end
    endcase

    done_s = (state_s == ST_FINISH);
    busy_s = (state_s != ST_IDLE);
  end

  // State, counters and registered outputs; reset drops the panel into hard reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {CW{1'b0}};
      delay_len_r   <= {CW{1'b0}};
      rom_addr_r    <= {AW{1'b0}};
      data_r        <= 8'h00;
      dc_r          <= 1'b0;
      write_start_r <= 1'b0;
      rst_oled_r    <= 1'b0;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
      error_r       <= 1'b0;
      start_d_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      delay_len_r   <= delay_len_s;
      rom_addr_r    <= rom_addr_s;
      data_r        <= data_s;
      dc_r          <= dc_s;
      write_start_r <= write_start_s;
      rst_oled_r    <= rst_oled_s;
      done_r        <= done_s;
      busy_r        <= busy_s;
      error_r       <= error_s;
      start_d_r     <= START;
    end
  end

  assign DONE        = done_r;
  assign BUSY        = busy_r;
  assign ERROR       = error_r;
  assign WRITE_START = write_start_r;
  assign DATA        = data_r;
  assign DC          = dc_r;
  assign RST_OLED    = rst_oled_r;
  assign ROM_ADDR    = rom_addr_r;

endmodule
